// File: rtl/integrator_mc_pkg.sv
// integrator_mc_pkg
// Shared types and helpers for the multi-channel integrator filter.
//   integ_state_t : per-channel FSM state (STABLE = no pending toggle,
//                   PENDING = counting differing samples)
//   cnt_width()   : counter width needed to hold 0..samples
package integrator_mc_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } integ_state_t;

  function automatic int cnt_width(input int samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/integrator_channel.sv
// integrator_channel
// One glitch-filter channel: out follows in only after in has differed
// from out on SAMPLES qualifying sample strobes.
// Optional feature macro: INTEGRATOR_MC_UPDOWN_EN
//   undefined : a matching sample clears the count (strict debounce)
//   defined   : a matching sample decrements the count (leaky integrator)
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   sample   sample strobe; channel only evaluates when high
//   in       raw channel input (already synchronised)
//   out      filtered output, registered
//   changed  one-cycle pulse on the cycle out toggles
//   busy     counter non-zero (toggle pending)
//   state    FSM state, exported for checkers
module integrator_channel
  import integrator_mc_pkg::*;
#(
  parameter int   SAMPLES   = 10,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample,
  input  logic         in,
  output logic         out,
  output logic         changed,
  output logic         busy,
  output integ_state_t state
);

  localparam int CNT_W = cnt_width(SAMPLES);
  // Count value at which the next differing sample completes the toggle.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  integ_state_t     state_n;
  logic             out_n;
  logic             changed_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STABLE;
      cnt     <= '0;
      out     <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      out     <= out_n;
      changed <= changed_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    out_n     = out;
    changed_n = 1'b0;
    if (sample) begin
      if (in != out) begin
        // With SAMPLES=1, LAST is 0 so a STABLE channel toggles at once.
        if (cnt == LAST) begin
          out_n     = ~out;
          cnt_n     = '0;
          state_n   = STABLE;
          changed_n = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          state_n = PENDING;
        end
      end else if (state == PENDING) begin
`ifdef INTEGRATOR_MC_UPDOWN_EN
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end
        if (cnt <= CNT_W'(1)) begin
          state_n = STABLE;
        end
`else
        cnt_n   = '0;
        state_n = STABLE;
`endif
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/integrator_mc.sv
// integrator_mc
// Multi-channel glitch filter for noisy 1-bit comparator outputs.
// Each channel is an independent integrator_channel sharing clk, rst, sample.
// Optional feature macro: INTEGRATOR_MC_UPDOWN_EN (see integrator_channel).
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   sample   sample strobe shared by all channels
//   in       [CHANNELS] raw inputs, synchronised upstream
//   out      [CHANNELS] filtered outputs, registered
//   changed  [CHANNELS] one-cycle toggle pulses
//   busy     [CHANNELS] toggle pending per channel
module integrator_mc
  import integrator_mc_pkg::*;
#(
  parameter int   CHANNELS  = 4,
  parameter int   SAMPLES   = 10,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] changed,
  output logic [CHANNELS-1:0] busy
);

  // Per-channel FSM state, kept as a named array so checkers can bind to it.
  integ_state_t ch_state [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    integrator_channel #(
      .SAMPLES   (SAMPLES),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .sample  (sample),
      .in      (in[g]),
      .out     (out[g]),
      .changed (changed[g]),
      .busy    (busy[g]),
      .state   (ch_state[g])
    );
  end

endmodule

// File: tb/tb_integrator_mc.sv
// tb_integrator_mc
// Directed bench for integrator_mc with CHANNELS=4, SAMPLES=4, RESET_VAL=0.
// Each driven cycle pushes its hand-computed post-edge {out,changed,busy}
// into exp_q; an independent monitor pops and compares after every edge.
module tb_integrator_mc;

  localparam int CH = 4;
  localparam int W  = 3 * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample = 1'b1;
  logic [CH-1:0] in = '0;
  logic [CH-1:0] out;
  logic [CH-1:0] changed;
  logic [CH-1:0] busy;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           n_step = 0;

  integrator_mc #(
    .CHANNELS  (CH),
    .SAMPLES   (4),
    .RESET_VAL (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample),
    .in      (in),
    .out     (out),
    .changed (changed),
    .busy    (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: apply one cycle of stimulus and queue the expected result
  task automatic step(input logic r, input logic s, input logic [CH-1:0] i,
                      input logic [CH-1:0] e_out, input logic [CH-1:0] e_chg,
                      input logic [CH-1:0] e_busy);
    @(negedge clk);
    rst    = r;
    sample = s;
    in     = i;
    exp_q.push_back({e_out, e_chg, e_busy});
    id_q.push_back(n_step);
    n_step++;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] exp_v;
    int           id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        id    = id_q.pop_front();
        n_cmp++;
        if ({out, changed, busy} !== exp_v) begin
          n_fail++;
          $display("FAIL step%0d: got out=%b changed=%b busy=%b, expected out=%b changed=%b busy=%b",
                   id, out, changed, busy, exp_v[W-1 -: CH], exp_v[2*CH-1 -: CH], exp_v[CH-1:0]);
        end
      end
    end
  end

  initial begin
    // reset with all inputs high
    step(1, 1, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    step(1, 1, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 4'h0, 4'b0000, 4'b0000, 4'b0000);

    // clean step on channel 0
    step(0, 1, 4'h1, 4'b0000, 4'b0000, 4'b0001);
    step(0, 1, 4'h1, 4'b0000, 4'b0000, 4'b0001);
    step(0, 1, 4'h1, 4'b0000, 4'b0000, 4'b0001);
    step(0, 1, 4'h1, 4'b0001, 4'b0001, 4'b0000);
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0000);

    // glitch on channel 1: three differing samples, then back low
    step(0, 1, 4'h3, 4'b0001, 4'b0000, 4'b0010);
    step(0, 1, 4'h3, 4'b0001, 4'b0000, 4'b0010);
    step(0, 1, 4'h3, 4'b0001, 4'b0000, 4'b0010);
`ifdef INTEGRATOR_MC_UPDOWN_EN
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0010);
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0010);
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0000);
`else
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 4'h1, 4'b0001, 4'b0000, 4'b0000);
`endif

    // strobe gating on channel 2: one strobe in three; in[2] drops
    // between strobes without effect
    step(0, 1, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 0, 4'h1, 4'b0001, 4'b0000, 4'b0100);
    step(0, 0, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 1, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 0, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 0, 4'h1, 4'b0001, 4'b0000, 4'b0100);
    step(0, 1, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 0, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 0, 4'h5, 4'b0001, 4'b0000, 4'b0100);
    step(0, 1, 4'h5, 4'b0101, 4'b0100, 4'b0000);
    step(0, 0, 4'h5, 4'b0101, 4'b0000, 4'b0000);
    step(0, 0, 4'h5, 4'b0101, 4'b0000, 4'b0000);

    // reset mid-count on channel 3: no toggle at the reset edge, all
    // outputs return to 0 and the count restarts from scratch
    step(0, 1, 4'hD, 4'b0101, 4'b0000, 4'b1000);
    step(0, 1, 4'hD, 4'b0101, 4'b0000, 4'b1000);
    step(1, 1, 4'hD, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 4'hD, 4'b0000, 4'b0000, 4'b1101);
    step(0, 1, 4'hD, 4'b0000, 4'b0000, 4'b1101);
    step(0, 1, 4'hD, 4'b0000, 4'b0000, 4'b1101);
    step(0, 1, 4'hD, 4'b1101, 4'b1101, 4'b0000);

    // channel independence: target 0101, in[1] glitching every cycle
    step(0, 1, 4'h7, 4'b1101, 4'b0000, 4'b1010);
    step(0, 1, 4'h5, 4'b1101, 4'b0000, 4'b1000);
    step(0, 1, 4'h7, 4'b1101, 4'b0000, 4'b1010);
    step(0, 1, 4'h5, 4'b0101, 4'b1000, 4'b0000);
    step(0, 1, 4'h7, 4'b0101, 4'b0000, 4'b0010);
    step(0, 1, 4'h5, 4'b0101, 4'b0000, 4'b0000);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
